// File: rtl/csa_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, sequencer
// state encoding and a helper that extracts one nibble from a wide vector.
package csa_pkg;

    localparam int NIB   = 4;
    // Widest operand nib_sel can address; callers zero-extend to this width.
    localparam int MAX_W = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Returns nibble number idx (LSB-first) of vec.
    function automatic logic [NIB-1:0] nib_sel(input logic [MAX_W-1:0] vec,
                                               input int unsigned      idx);
        return vec[idx*NIB +: NIB];
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand-in / result-out handshake bundle of the nibble-serial adder.
interface nibble_serial_adder_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    // Adder side.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

endinterface

// File: rtl/csa_nibble_slice.sv
// 4-bit carry-select adder slice: both carry-in cases are summed in
// parallel and the real carry-in only picks one of them.
module csa_nibble_slice
    import csa_pkg::*;
(
    input  logic [NIB-1:0] a,
    input  logic [NIB-1:0] b,
    input  logic           cin,
    output logic [NIB-1:0] s,
    output logic           cout
);

    logic [NIB:0] sum_c0;
    logic [NIB:0] sum_c1;

    // Precompute sums for cin=0 and cin=1, then select.
    always_comb begin
        sum_c0    = {1'b0, a} + {1'b0, b};
        sum_c1    = {1'b0, a} + {1'b0, b} + (NIB+1)'(1);
        {cout, s} = cin ? sum_c1 : sum_c0;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial sequencer around one 4-bit carry-select slice. Latches an
// operand pair, adds one nibble per cycle LSB-first with the carry held in
// a register, then presents sum, carry-out and signed overflow until taken.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    nibble_serial_adder_if.slave   bus,
    output logic                   busy
);

    import csa_pkg::*;

    localparam int N  = WIDTH / NIB;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [NIB-1:0]   slice_a, slice_b, slice_s;
    logic             slice_cout;

    // Route the current nibble of each latched operand to the slice.
    always_comb begin
        slice_a = nib_sel(MAX_W'(a_q), 32'(idx_q));
        slice_b = nib_sel(MAX_W'(b_q), 32'(idx_q));
    end

    csa_nibble_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case leaves one unassigned, which would infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*NIB +: NIB] = slice_s;
                carry_d = slice_cout;
                if (idx_q == IW'(N-1)) begin
                    // Final nibble: capture flags; slice_s[NIB-1] is the
                    // sum MSB being written this cycle.
                    cout_d  = slice_cout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (slice_s[NIB-1] != a_q[WIDTH-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign busy          = (state_q != IDLE);
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;

endmodule
